// File: rtl/trans_pkg.sv
// Shared transaction word layout for the assembler and the downstream validator.
package trans_pkg;

  localparam int unsigned TRANS_W         = 128;
  localparam int unsigned BYTES_PER_TRANS = 16;

  localparam int unsigned SENDER_MSB      = 127;
  localparam int unsigned SENDER_LSB      = 80;
  localparam int unsigned RECEIVER_MSB    = 79;
  localparam int unsigned RECEIVER_LSB    = 32;
  localparam int unsigned AMOUNT_MSB      = 31;
  localparam int unsigned AMOUNT_LSB      = 10;
  localparam int unsigned BLOCK_START_BIT = 9;

  typedef logic [TRANS_W-1:0] trans_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; pop_data updates only on a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pop_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        pop_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/trans_assembler.sv
// Packs 16 received bytes (first byte = MSB) into 128-bit words, buffers them and
// hands them to the validator over a data/valid/registered-ack interface.
module trans_assembler
  import trans_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned DROP_CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    byte_i,
  input  logic                          byte_valid_i,
  output logic [TRANS_W-1:0]            data_o,
  output logic                          valid_o,
  input  logic                          ack_i,
  output logic [DROP_CNT_W-1:0]         drop_cnt_o,
  output logic                          sync_err_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int unsigned CNT_W  = $clog2(BYTES_PER_TRANS);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES) + 1;

  // The final byte goes straight into the pushed word, so only 15 bytes are held.
  logic [TRANS_W-9:0]  head_q;
  logic [TRANS_W-1:0]  push_word;
  logic [CNT_W-1:0]    byte_cnt;
  logic [IDLE_W-1:0]   idle_cnt;
  logic                push;
  logic                timeout;
  logic                full;
  logic                empty;
  logic                pop;
  logic                load;
  logic                presented_q;

  assign push      = byte_valid_i & (byte_cnt == CNT_W'(BYTES_PER_TRANS-1));
  assign push_word = {head_q, byte_i};
  assign timeout   = ~byte_valid_i & (byte_cnt != '0) &
                     (idle_cnt == IDLE_W'(TIMEOUT_CYCLES-1));
  assign pop       = presented_q & ack_i;
  assign load      = (~valid_o | pop) & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= '0;
      byte_cnt   <= '0;
      idle_cnt   <= '0;
      sync_err_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      for (int unsigned k = 0; k < BYTES_PER_TRANS-1; k++) begin
        if (byte_valid_i && byte_cnt == CNT_W'(k))
          head_q[(BYTES_PER_TRANS-2-k)*8 +: 8] <= byte_i;
      end
      if (byte_valid_i)
        byte_cnt <= push ? '0 : byte_cnt + 1'b1;
      else if (timeout)
        byte_cnt <= '0;
      if (byte_valid_i || timeout || byte_cnt == '0)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;
      sync_err_o <= timeout;
      if (push && full && drop_cnt_o != '1)
        drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end

  // presented_q masks the ack that arrives the cycle after a fresh load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_o     <= 1'b0;
      presented_q <= 1'b0;
    end else begin
      presented_q <= valid_o & ~pop;
      if (load)
        valid_o <= 1'b1;
      else if (pop)
        valid_o <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (TRANS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_word),
    .pop       (load),
    .pop_data  (data_o),
    .full      (full),
    .empty     (empty),
    .level     (level_o)
  );

endmodule

// File: tb/tb_trans_assembler.sv
// Directed bench for trans_assembler with a behavioural validator driving ack_i.
module tb_trans_assembler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   byte_i = '0;
  logic         byte_valid_i = 1'b0;
  logic [127:0] data_o;
  logic         valid_o;
  logic         ack_i;
  logic [15:0]  drop_cnt_o;
  logic         sync_err_o;
  logic [2:0]   level_o;

  int tests = 0;
  int fails = 0;

  typedef enum logic [1:0] {V_IDLE, V_ACK, V_BUSY} vstate_t;
  vstate_t      vstate = V_IDLE;
  logic         ack_en = 1'b0;
  int           vbusy = 0;
  int           busy_cnt = 0;
  logic [127:0] cap = '0;
  logic [127:0] rx_q[$];

  always #5 clk = ~clk;

  trans_assembler #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (20),
    .DROP_CNT_W     (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ack_i        (ack_i),
    .drop_cnt_o   (drop_cnt_o),
    .sync_err_o   (sync_err_o),
    .level_o      (level_o)
  );

  // Validator: samples when idle, acks the following cycle, then stays busy vbusy cycles.
  assign ack_i = ack_en && (vstate != V_BUSY);

  always @(posedge clk) begin
    case (vstate)
      V_IDLE: if (ack_en && valid_o) begin
        cap    <= data_o;
        vstate <= V_ACK;
      end
      V_ACK: begin
        rx_q.push_back(cap);
        if (vbusy == 0) vstate <= V_IDLE;
        else begin
          busy_cnt <= vbusy;
          vstate   <= V_BUSY;
        end
      end
      default: if (busy_cnt <= 1) vstate <= V_IDLE;
               else busy_cnt <= busy_cnt - 1;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_i       = b;
    byte_valid_i = 1'b1;
    tick();
    byte_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int k = 0; k < 16; k++) send_byte(base + 8'(k));
  endtask

  function automatic logic [127:0] mk_word(input logic [7:0] base);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < 16; k++) w[127-8*k -: 8] = base + 8'(k);
    return w;
  endfunction

  task automatic wait_rx(input int n, input int budget, input string tag);
    int i;
    i = 0;
    while (rx_q.size() < n && i < budget) begin
      tick();
      i++;
    end
    check(tag, 128'(rx_q.size() >= n), 128'd1);
  endtask

  initial begin
    int pulses;
    int first_at;
    logic [7:0] ovf_base [7];

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_valid", 128'(valid_o), 128'd0);
    check("rst_data", data_o, 128'd0);
    check("rst_drop", 128'(drop_cnt_o), 128'd0);
    check("rst_sync", 128'(sync_err_o), 128'd0);
    check("rst_level", 128'(level_o), 128'd0);
    rst_n  = 1'b1;
    ack_en = 1'b1;
    vbusy  = 0;
    tick();

    // Single frame and output latency
    send_frame(8'h00);
    check("lat_valid_e0", 128'(valid_o), 128'd0);
    tick();
    check("lat_valid_e1", 128'(valid_o), 128'd1);
    check("single_data", data_o, 128'h000102030405060708090A0B0C0D0E0F);
    wait_rx(1, 20, "single_rx_wait");
    tick();
    tick();
    check("single_rx_word", rx_q[0], 128'h000102030405060708090A0B0C0D0E0F);
    check("single_valid_after", 128'(valid_o), 128'd0);
    check("single_rx_count", 128'(rx_q.size()), 128'd1);

    // Handshake stall: validator busy 7 cycles per word
    rx_q.delete();
    vbusy = 7;
    send_frame(8'h20);
    send_frame(8'h40);
    send_frame(8'h60);
    wait_rx(3, 200, "stall_rx_wait");
    repeat (30) tick();
    check("stall_count", 128'(rx_q.size()), 128'd3);
    check("stall_w0", rx_q[0], mk_word(8'h20));
    check("stall_w1", rx_q[1], mk_word(8'h40));
    check("stall_w2", rx_q[2], mk_word(8'h60));
    check("stall_level", 128'(level_o), 128'd0);
    check("stall_drop", 128'(drop_cnt_o), 128'd0);

    // Overflow: ack held low, 7 frames into a 4-deep FIFO plus output register
    rx_q.delete();
    vbusy  = 0;
    ack_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ovf_base[i] = 8'h11 * 8'(i + 1);
      send_frame(ovf_base[i]);
    end
    tick();
    tick();
    check("ovf_level", 128'(level_o), 128'd4);
    check("ovf_drop", 128'(drop_cnt_o), 128'd2);
    check("ovf_valid", 128'(valid_o), 128'd1);
    check("ovf_head", data_o, mk_word(8'h11));
    ack_en = 1'b1;
    wait_rx(5, 200, "ovf_rx_wait");
    repeat (20) tick();
    check("ovf_rx_count", 128'(rx_q.size()), 128'd5);
    for (int i = 0; i < 5; i++) check($sformatf("ovf_w%0d", i), rx_q[i], mk_word(ovf_base[i]));
    check("ovf_level_end", 128'(level_o), 128'd0);

    // Timeout discards a 5-byte partial frame
    rx_q.delete();
    for (int k = 0; k < 5; k++) send_byte(8'hA0 + 8'(k));
    pulses   = 0;
    first_at = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (sync_err_o) begin
        pulses++;
        if (first_at == 0) first_at = i;
      end
    end
    check("to_pulses", 128'(pulses), 128'd1);
    check("to_pulse_pos", 128'(first_at), 128'd20);
    send_frame(8'h10);
    wait_rx(1, 20, "to_rx_wait");
    check("to_word", rx_q[0], 128'h101112131415161718191A1B1C1D1E1F);

    // Byte on the timeout boundary wins
    rx_q.delete();
    pulses = 0;
    for (int k = 0; k < 3; k++) send_byte(8'hC0 + 8'(k));
    for (int i = 0; i < 19; i++) begin
      tick();
      if (sync_err_o) pulses++;
    end
    for (int k = 3; k < 16; k++) begin
      send_byte(8'hC0 + 8'(k));
      if (sync_err_o) pulses++;
    end
    check("bnd_pulses", 128'(pulses), 128'd0);
    wait_rx(1, 20, "bnd_rx_wait");
    check("bnd_word", rx_q[0], mk_word(8'hC0));

    // Reset mid-operation with a pending word and a partial frame
    repeat (5) tick();
    rx_q.delete();
    ack_en = 1'b0;
    send_frame(8'hD0);
    for (int k = 0; k < 9; k++) send_byte(8'hE0 + 8'(k));
    check("mid_pending", 128'(valid_o), 128'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_valid", 128'(valid_o), 128'd0);
    check("mid_data", data_o, 128'd0);
    check("mid_drop", 128'(drop_cnt_o), 128'd0);
    check("mid_level", 128'(level_o), 128'd0);
    ack_en = 1'b1;
    send_frame(8'h30);
    wait_rx(1, 20, "mid_rx_wait");
    repeat (10) tick();
    check("mid_rx_count", 128'(rx_q.size()), 128'd1);
    check("mid_word", rx_q[0], mk_word(8'h30));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trans_assembler.md
Name: trans_assembler

Overview:
- Upstream stage of the transaction validator. Receives a byte stream from the receive front end and packs each 16 consecutive bytes into one 128-bit transaction word.
- Buffers completed words in a small FIFO and presents them to the validator over its data/valid/ack interface.
- Resynchronises on inter-byte timeout and counts words dropped because the buffer was full.

Parameters:
- FIFO_DEPTH, 4, number of complete 128-bit words buffered; excludes the output register; power of two, at least 2.
- TIMEOUT_CYCLES, 1024, idle cycles inside a partial frame after which the partial frame is discarded.
- DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- byte_i  in  8  received byte.
- byte_valid_i  in  1  byte_i valid this cycle; one byte per cycle maximum; no backpressure.
- data_o  out  128  transaction word to the validator: [127:80] sender, [79:32] receiver, [31:10] amount, [9] block start, [8:0] reserved.
- valid_o  out  1  data_o holds a word not yet accepted.
- ack_i  in  1  validator ack, registered on its side (see handshake).
- drop_cnt_o  out  DROP_CNT_W  saturating count of complete words dropped on overflow.
- sync_err_o  out  1  one-cycle pulse when a partial frame is discarded by timeout.
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy; excludes the output register.

Behaviour:
- Reset (rst_n=0 at an edge) values: valid_o=0, data_o=0, drop_cnt_o=0, sync_err_o=0, level_o=0. Byte counter, idle counter, FIFO pointers and presented_q are cleared. A partial frame or an un-acked word present at reset is lost.
- Packing:
  - byte_cnt runs 0..15. Byte k of a frame goes to bits [127-8k -: 8], so the first byte is the MSB.
  - On the 16th byte, byte_cnt wraps to 0 and the complete word is pushed into the FIFO on the next edge.
- Overflow:
  - Push is dropped if the FIFO is full at the push edge, even if a pop happens in the same cycle.
  - A drop increments drop_cnt_o, which saturates at all-ones.
- Timeout:
  - idle_cnt resets on every byte_valid_i and counts while byte_cnt!=0.
  - When idle_cnt reaches TIMEOUT_CYCLES-1, byte_cnt<=0 and sync_err_o pulses for 1 cycle.
  - If a byte arrives in that same cycle, the byte wins: no timeout fires and the byte is packed normally.
- Output register:
  - When valid_o=0 (or a pop occurs) and the FIFO is non-empty, the head is loaded into data_o and valid_o<=1.
  - Latency: with an empty pipeline, valid_o rises in the 2nd cycle after the edge that samples the 16th byte.
  - data_o is stable while valid_o=1.
- Handshake:
  - The validator samples data_i whenever it is idle and asserts ack one cycle later; ack is also high continuously while the validator is idle.
  - presented_q <= valid_o & ~pop.
  - pop = presented_q & ack_i. The word shown in cycle N counts as accepted iff ack_i=1 in cycle N+1.
  - On pop: load the next FIFO head, or set valid_o<=0 if the FIFO is empty.
  - ack_i while presented_q=0 is ignored, so the newly loaded word is never double-popped.
- Capacity: FIFO_DEPTH+1 words (FIFO plus output register) before drops begin.

Decomposition:
- Shared package trans_pkg holds:
  - Field bit positions: SENDER_MSB/LSB, RECEIVER_MSB/LSB, AMOUNT_MSB/LSB, BLOCK_START_BIT=9.
  - TRANS_W=128 and BYTES_PER_TRANS=16.
  - The validator also imports trans_pkg.
- One sub-module: sync_fifo, parameterised width/depth, with push/pop/full/empty/level and a registered read. This block instantiates it with width=TRANS_W.

Test Plan:
- Single frame: bytes 0x00..0x0F back-to-back, ack_i modelled as the validator → data_o=0x000102030405060708090A0B0C0D0E0F, valid_o high 2 cycles after the last byte, popped on the first ack, valid_o=0 afterwards.
- Handshake stall: 3 frames sent, validator busy for 7 cycles per word → words delivered in order, each exactly once, level_o returns to 0, drop_cnt_o=0.
- Overflow: ack_i held 0, 7 frames sent with FIFO_DEPTH=4 → 5 words retained, drop_cnt_o=2; then ack released → 5 words out in order.
- Timeout: 5 bytes, TIMEOUT_CYCLES idle, then 16 bytes 0x10..0x1F → sync_err_o one pulse, next data_o=0x101112...1F.
- Byte on the timeout boundary: 3 bytes, idle TIMEOUT_CYCLES-1, then a byte → no sync_err_o; frame continues from byte 4.
- Reset mid-operation: rst_n low for 1 cycle after 9 bytes with one word pending → valid_o=0, drop_cnt_o=0, level_o=0; the next 16 bytes form a clean word.
